tlk2711_tx_ctrl: RTL and testbench



---
 rtl/tlk2711_tx_ctrl_if.sv | 31 +++
 rtl/tlk2711_tx_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_tlk2711_tx_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlk2711_tx_ctrl_if.sv
// rtl/tlk2711_tx_ctrl_if.sv - DMA read-command channel between tlk2711_tx_ctrl and the DMA engine
//
// Purpose: carries one read command per valid/ready transfer, plus the
// in-order completion pulse that returns from the DMA engine.
// Signals:
//   dma_cmd_valid  controller -> DMA  command presented
//   dma_cmd_ready  DMA -> controller  command accepted when sampled with valid
//   dma_cmd_addr   controller -> DMA  command byte address (ADDR_WIDTH)
//   dma_cmd_len    controller -> DMA  command length in bytes, multiple of 8
//   dma_cmd_done   DMA -> controller  one-cycle pulse per completed command
// Modports: master = controller side, slave = DMA engine side.

interface tlk2711_tx_ctrl_if #(
    parameter int ADDR_WIDTH = 32
) ();
    logic                  dma_cmd_valid;
    logic                  dma_cmd_ready;
    logic [ADDR_WIDTH-1:0] dma_cmd_addr;
    logic [15:0]           dma_cmd_len;
    logic                  dma_cmd_done;

    modport master (
        output dma_cmd_valid, dma_cmd_addr, dma_cmd_len,
        input  dma_cmd_ready, dma_cmd_done
    );

    modport slave (
        input  dma_cmd_valid, dma_cmd_addr, dma_cmd_len,
        output dma_cmd_ready, dma_cmd_done
    );
endinterface

// File: rtl/tlk2711_tx_ctrl.sv
// rtl/tlk2711_tx_ctrl.sv - TLK2711 transmit controller: frame split, DMA command issue, completion tracking
//
// Purpose: on i_tx_go, splits i_tx_total_len into body-sized frames, pulses
// o_tx_start to the TX datapath, issues one DMA read per frame (length rounded
// up to 8 bytes, at most MAX_OUTSTANDING in flight), then waits for all
// completions and the datapath interrupt before pulsing o_done.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_soft_reset        synchronous abort, same effect as rst
//   i_tx_go             start pulse, honoured only in IDLE
//   i_tx_base_addr      byte address of the first frame
//   i_tx_total_len      total payload bytes
//   i_tx_packet_body    body-frame payload bytes
//   o_tx_start          one-cycle start pulse to the datapath
//   o_tx_body_num       index of the last frame
//   o_tx_packet_tail    payload bytes of the last frame
//   dma                 DMA command channel (master modport)
//   i_tx_interrupt      datapath "last frame sent" pulse
//   o_busy, o_done      not-IDLE flag, one-cycle completion pulse
//   o_err               sticky flags: [0] configuration error, [1] timeout
// Build option: define TLK2711_TX_CTRL_TIMEOUT_EN to build the DMA-completion
// watchdog (TIMEOUT_CYCLES); otherwise o_err[1] is tied to 0.

module tlk2711_tx_ctrl #(
    parameter int ADDR_WIDTH      = 32,
    parameter int LEN_WIDTH       = 24,
    parameter int MAX_OUTSTANDING = 2,
    parameter int TIMEOUT_CYCLES  = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_soft_reset,
    input  logic                  i_tx_go,
    input  logic [ADDR_WIDTH-1:0] i_tx_base_addr,
    input  logic [LEN_WIDTH-1:0]  i_tx_total_len,
    input  logic [15:0]           i_tx_packet_body,
    output logic                  o_tx_start,
    output logic [15:0]           o_tx_body_num,
    output logic [15:0]           o_tx_packet_tail,
    tlk2711_tx_ctrl_if.master     dma,
    input  logic                  i_tx_interrupt,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [1:0]            o_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CALC  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    localparam logic [2:0] MAX_OUT = 3'(MAX_OUTSTANDING);

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_base_addr;
    logic [ADDR_WIDTH-1:0] r_cmd_addr;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic [15:0]           r_body_len;
    logic [15:0]           r_body_cnt;
    logic [15:0]           r_frame_idx;
    logic [15:0]           r_tx_body_num;
    logic [15:0]           r_tx_packet_tail;
    logic [2:0]            r_outstanding;
    logic                  r_intr_seen;
    logic                  r_cmd_valid;
    logic                  r_done;
    logic                  r_err_cfg;

    logic                  w_reset;
    logic                  w_go_accept;
    logic                  w_xfer;
    logic                  w_done_eff;
    logic                  w_last_frame;
    logic                  w_timeout;
    logic [2:0]            w_out_next;
    logic [LEN_WIDTH-1:0]  w_body_ext;
    logic [15:0]           w_frame_len;

    assign w_reset      = rst | i_soft_reset;
    assign w_go_accept  = (r_state == S_IDLE) & i_tx_go;
    assign w_xfer       = r_cmd_valid & dma.dma_cmd_ready;
    // A completion with nothing in flight is a stray pulse; drop it so the counter cannot wrap.
    assign w_done_eff   = dma.dma_cmd_done & (r_outstanding != 3'd0);
    assign w_out_next   = r_outstanding + 3'(w_xfer) - 3'(w_done_eff);
    assign w_body_ext   = LEN_WIDTH'(r_body_len);
    assign w_last_frame = (r_frame_idx == r_tx_body_num);
    assign w_frame_len  = w_last_frame ? r_tx_packet_tail : r_body_len;

    assign dma.dma_cmd_valid = r_cmd_valid;
    assign dma.dma_cmd_addr  = r_cmd_addr;
    // Length follows the frame index, which only moves on a transfer, so it holds while valid waits.
    assign dma.dma_cmd_len   = (w_frame_len + 16'd7) & 16'hFFF8;

    assign o_tx_start       = (r_state == S_START);
    assign o_busy           = (r_state != S_IDLE);
    assign o_done           = r_done;
    assign o_tx_body_num    = r_tx_body_num;
    assign o_tx_packet_tail = r_tx_packet_tail;

`ifdef TLK2711_TX_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_err_to;

    // Fires on the cycle the DMA has gone TIMEOUT_CYCLES without completing anything.
    assign w_timeout = (r_outstanding != 3'd0) && !w_done_eff &&
                       (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (w_reset) begin
            r_wd_cnt <= '0;
            r_err_to <= 1'b0;
        end else begin
            if ((r_outstanding == 3'd0) || w_done_eff || w_timeout)
                r_wd_cnt <= '0;
            else
                r_wd_cnt <= r_wd_cnt + WD_W'(1);

            if (w_timeout)
                r_err_to <= 1'b1;
            else if (w_go_accept)
                r_err_to <= 1'b0;
        end
    end

    assign o_err = {r_err_to, r_err_cfg};
`else
    assign w_timeout = 1'b0;
    assign o_err     = {1'b0, r_err_cfg};
`endif

    always_ff @(posedge clk) begin
        if (w_reset || w_timeout) begin
            r_state       <= S_IDLE;
            r_cmd_valid   <= 1'b0;
            r_done        <= 1'b0;
            r_outstanding <= 3'd0;
            r_intr_seen   <= 1'b0;
            r_base_addr   <= '0;
            r_cmd_addr    <= '0;
            r_remaining   <= '0;
            r_body_len    <= 16'd0;
            r_body_cnt    <= 16'd0;
            r_frame_idx   <= 16'd0;
            // A watchdog abort leaves the last split result and config flag visible.
            if (w_reset) begin
                r_err_cfg        <= 1'b0;
                r_tx_body_num    <= 16'd0;
                r_tx_packet_tail <= 16'd0;
            end
        end else begin
            r_done        <= 1'b0;
            r_outstanding <= w_out_next;
            if ((r_state != S_IDLE) && i_tx_interrupt)
                r_intr_seen <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (i_tx_go) begin
                        r_base_addr <= i_tx_base_addr;
                        r_remaining <= i_tx_total_len;
                        r_body_len  <= i_tx_packet_body;
                        r_body_cnt  <= 16'd0;
                        r_err_cfg   <= 1'b0;
                        r_state     <= S_CALC;
                    end
                end
                S_CALC: begin
                    // remaining never reaches 0 by subtraction, so this only catches a zero total.
                    if ((r_remaining == '0) || (r_body_len == 16'd0)) begin
                        r_err_cfg   <= 1'b1;
                        r_intr_seen <= 1'b0;
                        r_state     <= S_IDLE;
                    end else if (r_remaining > w_body_ext) begin
                        if (r_body_cnt == 16'hFFFF) begin
                            r_err_cfg   <= 1'b1;
                            r_intr_seen <= 1'b0;
                            r_state     <= S_IDLE;
                        end else begin
                            r_remaining <= r_remaining - w_body_ext;
                            r_body_cnt  <= r_body_cnt + 16'd1;
                        end
                    end else begin
                        r_tx_body_num    <= r_body_cnt;
                        r_tx_packet_tail <= r_remaining[15:0];
                        r_state          <= S_START;
                    end
                end
                S_START: begin
                    r_cmd_addr  <= r_base_addr;
                    r_frame_idx <= 16'd0;
                    r_state     <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (w_xfer) begin
                        if (w_last_frame) begin
                            r_cmd_valid <= 1'b0;
                            r_state     <= S_DRAIN;
                        end else begin
                            r_frame_idx <= r_frame_idx + 16'd1;
                            r_cmd_addr  <= r_cmd_addr + ADDR_WIDTH'(r_body_len);
                            // Back-to-back presentation when the window still has room.
                            r_cmd_valid <= (w_out_next < MAX_OUT);
                        end
                    end else if (!r_cmd_valid) begin
                        r_cmd_valid <= (w_out_next < MAX_OUT);
                    end
                end
                S_DRAIN: begin
                    if ((r_outstanding == 3'd0) && r_intr_seen) begin
                        r_intr_seen <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tlk2711_tx_ctrl.sv
// tb/tb_tlk2711_tx_ctrl.sv - scoreboard bench for tlk2711_tx_ctrl

module tb_tlk2711_tx_ctrl;

    localparam int AW = 32;
    localparam int LW = 24;
    localparam int MO = 2;
    localparam int TO = 100;

    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   len;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_soft_reset = 1'b0;
    logic          i_tx_go = 1'b0;
    logic [AW-1:0] i_tx_base_addr = '0;
    logic [LW-1:0] i_tx_total_len = '0;
    logic [15:0]   i_tx_packet_body = '0;
    logic          i_tx_interrupt = 1'b0;
    logic          o_tx_start;
    logic [15:0]   o_tx_body_num;
    logic [15:0]   o_tx_packet_tail;
    logic          o_busy;
    logic          o_done;
    logic [1:0]    o_err;

    tlk2711_tx_ctrl_if #(.ADDR_WIDTH(AW)) dma_if ();

    tlk2711_tx_ctrl #(
        .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .MAX_OUTSTANDING(MO), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .i_soft_reset(i_soft_reset), .i_tx_go(i_tx_go),
        .i_tx_base_addr(i_tx_base_addr), .i_tx_total_len(i_tx_total_len),
        .i_tx_packet_body(i_tx_packet_body), .o_tx_start(o_tx_start),
        .o_tx_body_num(o_tx_body_num), .o_tx_packet_tail(o_tx_packet_tail),
        .dma(dma_if.master), .i_tx_interrupt(i_tx_interrupt),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   xfer_cnt = 0;
    int   start_cnt = 0;
    int   done_cnt = 0;
    bit   done_auto = 1'b0;
    int   due_q[$];
    cmd_t exp_q[$];
    cmd_t mon_e;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // DMA model and monitor: completions are driven at the falling edge,
    // transfers and pulses are sampled 1 ns before the rising edge.
    initial begin
        dma_if.dma_cmd_done = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                dma_if.dma_cmd_done = 1'b1;
                void'(due_q.pop_front());
            end else begin
                dma_if.dma_cmd_done = 1'b0;
            end
            #4;
            if (dma_if.dma_cmd_valid && dma_if.dma_cmd_ready && !rst && !i_soft_reset) begin
                xfer_cnt++;
                chk("cmd_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("cmd_addr", dma_if.dma_cmd_addr, mon_e.addr);
                    chk("cmd_len", dma_if.dma_cmd_len, mon_e.len);
                end
                if (done_auto) due_q.push_back(cyc + 20);
            end
            if (o_tx_start) start_cnt++;
            if (o_done) done_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    // Reference split by division, independent of the DUT's subtraction loop.
    task automatic push_cmds(input logic [AW-1:0] base, input int total, input int body);
        int num;
        int tail;
        num  = (total - 1) / body;
        tail = total - num * body;
        for (int k = 0; k <= num; k++) begin
            cmd_t c;
            c.addr = base + AW'(k * body);
            c.len  = 16'((((k == num) ? tail : body) + 7) & ~7);
            exp_q.push_back(c);
        end
    endtask

    task automatic pulse_go(input logic [AW-1:0] base, input int total, input int body);
        i_tx_base_addr   = base;
        i_tx_total_len   = LW'(total);
        i_tx_packet_body = 16'(body);
        i_tx_go = 1'b1;
        tick(1);
        i_tx_go = 1'b0;
    endtask

    task automatic wait_start(input string tag, input int s0, input int exp_num, input int exp_tail);
        int n;
        n = 0;
        while (start_cnt == s0 && n < 100) begin
            tick(1);
            n++;
        end
        chk({tag, "_start_seen"}, start_cnt != s0, 1);
        chk({tag, "_body_num"}, o_tx_body_num, exp_num);
        chk({tag, "_tail"}, o_tx_packet_tail, exp_tail);
        chk({tag, "_err"}, o_err, 2'b00);
    endtask

    task automatic finish_xfer(input string tag, input int s0, input int d0, input int intr_delay);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            tick(1);
            n++;
        end
        chk({tag, "_cmds_left"}, exp_q.size(), 0);
        if (intr_delay > 0) begin
            tick(intr_delay);
            chk({tag, "_no_done_before_intr"}, done_cnt - d0, 0);
            chk({tag, "_busy_before_intr"}, o_busy, 1);
        end
        i_tx_interrupt = 1'b1;
        tick(1);
        i_tx_interrupt = 1'b0;
        n = 0;
        while (done_cnt == d0 && n < 2000) begin
            tick(1);
            n++;
        end
        chk({tag, "_done"}, done_cnt - d0, 1);
        chk({tag, "_start_count"}, start_cnt - s0, 1);
        tick(1);
        chk({tag, "_idle"}, o_busy, 0);
        chk({tag, "_done_single"}, done_cnt - d0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1, "bench stalled");
    end

    initial begin
        int s0;
        int d0;
        int x0;
        int n;

        dma_if.dma_cmd_ready = 1'b0;
        tick(3);
        chk("rst_busy", o_busy, 0);
        chk("rst_valid", dma_if.dma_cmd_valid, 0);
        chk("rst_start", o_tx_start, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_err, 2'b00);
        chk("rst_body_num", o_tx_body_num, 0);
        chk("rst_tail", o_tx_packet_tail, 0);
        rst = 1'b0;
        tick(2);

        // Two full frames, exact multiple of body.
        dma_if.dma_cmd_ready = 1'b1;
        done_auto = 1'b1;
        s0 = start_cnt; d0 = done_cnt;
        push_cmds(32'h1000, 1740, 870);
        pulse_go(32'h1000, 1740, 870);
        wait_start("t1740", s0, 1, 870);
        finish_xfer("t1740", s0, d0, 0);

        // Zero total length.
        s0 = start_cnt; x0 = xfer_cnt;
        pulse_go(32'h2000, 0, 870);
        tick(1);
        chk("zero_err", o_err, 2'b01);
        chk("zero_busy", o_busy, 0);
        tick(3);
        chk("zero_no_start", start_cnt - s0, 0);
        chk("zero_no_cmd", xfer_cnt - x0, 0);

        // Short tail; the accepted go also clears the sticky config error.
        s0 = start_cnt; d0 = done_cnt;
        push_cmds(32'h1000, 1000, 870);
        pulse_go(32'h1000, 1000, 870);
        wait_start("t1000", s0, 1, 130);
        finish_xfer("t1000", s0, d0, 40);

        // Zero body length.
        s0 = start_cnt;
        pulse_go(32'h2000, 100, 0);
        tick(1);
        chk("body0_err", o_err, 2'b01);
        chk("body0_busy", o_busy, 0);

        // Single frame smaller than body.
        s0 = start_cnt; d0 = done_cnt;
        push_cmds(32'h3000, 100, 870);
        pulse_go(32'h3000, 100, 870);
        wait_start("t100", s0, 0, 100);
        finish_xfer("t100", s0, d0, 0);

        // Soft reset with a command waiting for ready and one in flight.
        done_auto = 1'b0;
        x0 = xfer_cnt;
        push_cmds(32'h4000, 1740, 870);
        pulse_go(32'h4000, 1740, 870);
        n = 0;
        while (xfer_cnt == x0 && n < 100) begin
            tick(1);
            n++;
        end
        dma_if.dma_cmd_ready = 1'b0;
        chk("sr_valid_waiting", dma_if.dma_cmd_valid, 1);
        tick(3);
        chk("sr_valid_held", dma_if.dma_cmd_valid, 1);
        chk("sr_addr_held", dma_if.dma_cmd_addr, 32'h4366);
        chk("sr_len_held", dma_if.dma_cmd_len, 16'd872);
        i_soft_reset = 1'b1;
        tick(1);
        i_soft_reset = 1'b0;
        chk("sr_valid", dma_if.dma_cmd_valid, 0);
        chk("sr_busy", o_busy, 0);
        chk("sr_outstanding", dut.r_outstanding, 0);
        chk("sr_body_num", o_tx_body_num, 0);
        chk("sr_tail", o_tx_packet_tail, 0);
        exp_q.delete();
        due_q.delete();
        tick(2);

        // Outstanding window with completions withheld, then ready stalls.
        dma_if.dma_cmd_ready = 1'b1;
        s0 = start_cnt; d0 = done_cnt; x0 = xfer_cnt;
        push_cmds(32'h8000, 8700, 870);
        pulse_go(32'h8000, 8700, 870);
        wait_start("t8700", s0, 9, 870);
        tick(30);
        chk("mo_xfers_before_done", xfer_cnt - x0, MO);
        chk("mo_valid_blocked", dma_if.dma_cmd_valid, 0);
        dma_if.dma_cmd_ready = 1'b0;
        due_q.push_back(cyc);
        n = 0;
        while (!dma_if.dma_cmd_valid && n < 20) begin
            tick(1);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("mo_stall_valid", dma_if.dma_cmd_valid, 1);
            chk("mo_stall_addr", dma_if.dma_cmd_addr, exp_q[0].addr);
            chk("mo_stall_len", dma_if.dma_cmd_len, exp_q[0].len);
            tick(1);
        end
        chk("mo_no_xfer_stalled", xfer_cnt - x0, MO);
        dma_if.dma_cmd_ready = 1'b1;
        due_q.push_back(cyc + 2);
        done_auto = 1'b1;
        finish_xfer("t8700", s0, d0, 0);

`ifdef TLK2711_TX_CTRL_TIMEOUT_EN
        // Completion never arrives: watchdog aborts without o_done.
        done_auto = 1'b0;
        d0 = done_cnt; x0 = xfer_cnt;
        push_cmds(32'hA000, 870, 870);
        pulse_go(32'hA000, 870, 870);
        n = 0;
        while (xfer_cnt == x0 && n < 50) begin
            tick(1);
            n++;
        end
        tick(90);
        chk("to_not_yet", o_err, 2'b00);
        n = 0;
        while (!o_err[1] && n < 30) begin
            tick(1);
            n++;
        end
        chk("to_err", o_err, 2'b10);
        chk("to_busy", o_busy, 0);
        chk("to_valid", dma_if.dma_cmd_valid, 0);
        tick(5);
        chk("to_no_done", done_cnt - d0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
